// File: rtl/mdu_pkg.sv
// Shared types for the HI/LO multiply/divide unit: operation encoding and FSM states.
package mdu_pkg;

    typedef enum logic [1:0] {
        MULT  = 2'd0,
        MULTU = 2'd1,
        DIV   = 2'd2,
        DIVU  = 2'd3
    } mdu_op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_WB   = 2'd2
    } mdu_state_t;

endpackage

// File: rtl/hilo_mdu.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// Shift-add multiply and restoring divide share one shift register and one adder.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | unit free; start accepted, direct HI/LO writes allowed
// ST_RUN  | one operand bit per cycle, WIDTH cycles
// ST_WB   | done pulse; sign-corrected result written to HI/LO
module hilo_mdu
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  mdu_op_t          op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] hi_data,
    input  logic [WIDTH-1:0] lo_data,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);

    mdu_state_t         state;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   opr;
    logic [CW-1:0]      cnt;
    logic               div_q;
    logic               neg_q;
    logic               neg_r;
    logic               div0;

    logic               accept;
    logic               op_signed;
    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [WIDTH:0]     add_x;
    logic [WIDTH:0]     add_y;
    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] acc_next;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   rem;
    logic [WIDTH-1:0]   res_hi;
    logic [WIDTH-1:0]   res_lo;

    assign accept    = (state == ST_IDLE) && start && !flush;
    assign op_signed = (op == MULT) || (op == DIV);
    assign a_neg     = op_signed && a[WIDTH-1];
    assign b_neg     = op_signed && b[WIDTH-1];
    assign a_mag     = a_neg ? -a : a;
    assign b_mag     = b_neg ? -b : b;

    // Divide looks at the remainder shifted left by one; multiply at the upper half.
    assign add_x = div_q ? acc[2*WIDTH-1:WIDTH-1] : {1'b0, acc[2*WIDTH-1:WIDTH]};
    assign add_y = {1'b0, opr};
    assign sum   = div_q ? (add_x - add_y) : (add_x + add_y);

    always_comb begin
        acc_next = acc;
        if (div_q) begin
            if (sum[WIDTH])
                acc_next = {acc[2*WIDTH-2:0], 1'b0};
            else
                acc_next = {sum[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        end else begin
            if (acc[0])
                acc_next = {sum, acc[WIDTH-1:1]};
            else
                acc_next = {1'b0, acc[2*WIDTH-1:1]};
        end
    end

    // Divide by zero naturally leaves |a| as remainder; only the quotient needs forcing.
    assign prod   = neg_q ? -acc : acc;
    assign quo    = acc[WIDTH-1:0];
    assign rem    = acc[2*WIDTH-1:WIDTH];
    assign res_lo = div_q ? (div0 ? {WIDTH{1'b1}} : (neg_q ? -quo : quo)) : prod[WIDTH-1:0];
    assign res_hi = div_q ? (neg_r ? -rem : rem) : prod[2*WIDTH-1:WIDTH];

    assign busy = (state != ST_IDLE);
    assign done = (state == ST_WB) && !flush;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
            acc   <= '0;
            opr   <= '0;
            cnt   <= '0;
            div_q <= 1'b0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
            div0  <= 1'b0;
            hi    <= '0;
            lo    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        state <= ST_RUN;
                        acc   <= {{WIDTH{1'b0}}, a_mag};
                        opr   <= b_mag;
                        cnt   <= CW'(WIDTH - 1);
                        div_q <= op[1];
                        neg_q <= a_neg ^ b_neg;
                        neg_r <= a_neg;
                        div0  <= (b == '0);
                    end else begin
                        if (hi_we)
                            hi <= hi_data;
                        if (lo_we)
                            lo <= lo_data;
                    end
                end
                ST_RUN: begin
                    if (flush) begin
                        state <= ST_IDLE;
                    end else begin
                        acc <= acc_next;
                        cnt <= cnt - 1'b1;
                        if (cnt == '0)
                            state <= ST_WB;
                    end
                end
                ST_WB: begin
                    state <= ST_IDLE;
                    if (!flush) begin
                        hi <= res_hi;
                        lo <= res_lo;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hilo_mdu.sv
// Directed self-checking bench for hilo_mdu at WIDTH=32.
module tb_hilo_mdu;
    import mdu_pkg::*;

    logic        clk;
    logic        reset;
    logic        start;
    mdu_op_t     op;
    logic [31:0] a, b;
    logic        flush;
    logic        hi_we, lo_we;
    logic [31:0] hi_data, lo_data;
    logic        busy, done;
    logic [31:0] hi, lo;

    int n_checks = 0;
    int n_fail   = 0;

    hilo_mdu #(.WIDTH(32)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .op      (op),
        .a       (a),
        .b       (b),
        .flush   (flush),
        .hi_we   (hi_we),
        .lo_we   (lo_we),
        .hi_data (hi_data),
        .lo_data (lo_data),
        .busy    (busy),
        .done    (done),
        .hi      (hi),
        .lo      (lo)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Issues one op and returns the number of cycles from the accepting edge to done
    // (100 means done never appeared). Returns at the negedge inside the done cycle.
    task automatic run_op(input mdu_op_t o, input logic [31:0] xa, input logic [31:0] xb,
                          output int cyc);
        @(negedge clk);
        start = 1'b1; op = o; a = xa; b = xb;
        @(posedge clk);
        #1 start = 1'b0;
        cyc = 0;
        while (cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (done) break;
        end
    endtask

    task automatic test_reset;
        n_checks++;
        if ({busy, done, hi, lo} !== 66'd0) begin
            n_fail++;
            $display("FAIL reset_state: busy=%b done=%b hi=%h lo=%h, want all 0", busy, done, hi, lo);
        end
    endtask

    task automatic test_multu_max;
        int cyc;
        run_op(MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, cyc);
        n_checks++;
        if (cyc !== 33) begin
            n_fail++;
            $display("FAIL multu_latency: done after %0d cycles, want 33", cyc);
        end
        @(negedge clk);
        n_checks++;
        if ({done, busy} !== 2'b00) begin
            n_fail++;
            $display("FAIL multu_done_pulse: done=%b busy=%b, want 0 0", done, busy);
        end
        n_checks++;
        if ({hi, lo} !== 64'hFFFFFFFE_00000001) begin
            n_fail++;
            $display("FAIL multu_max: hi=%h lo=%h, want FFFFFFFE 00000001", hi, lo);
        end
    endtask

    task automatic test_signed;
        int cyc;
        logic [31:0] vec_a [5] = '{32'hFFFFFFFD, 32'hFFFFFFF9, 32'h00000064, 32'h00000007, 32'hFFFFFFFB};
        logic [31:0] vec_b [5] = '{32'h00000005, 32'h00000002, 32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFFD};
        mdu_op_t     vec_o [5] = '{MULT, DIV, DIVU, DIV, MULT};
        logic [63:0] want  [5] = '{64'hFFFFFFFF_FFFFFFF1, 64'hFFFFFFFF_FFFFFFFD,
                                   64'h00000002_0000000E, 64'h00000001_FFFFFFFD,
                                   64'h00000000_0000000F};
        for (int i = 0; i < 5; i++) begin
            run_op(vec_o[i], vec_a[i], vec_b[i], cyc);
            @(negedge clk);
            n_checks++;
            if ({hi, lo} !== want[i]) begin
                n_fail++;
                $display("FAIL signed_vec%0d: hi=%h lo=%h, want %h", i, hi, lo, want[i]);
            end
        end
    endtask

    task automatic test_div_special;
        int cyc;
        run_op(DIVU, 32'h00001234, 32'h0, cyc);
        @(negedge clk);
        n_checks++;
        if ({hi, lo} !== 64'h00001234_FFFFFFFF) begin
            n_fail++;
            $display("FAIL divu_by_zero: hi=%h lo=%h, want 00001234 FFFFFFFF", hi, lo);
        end
        run_op(DIV, 32'hFFFFFFF0, 32'h0, cyc);
        @(negedge clk);
        n_checks++;
        if ({hi, lo} !== 64'hFFFFFFF0_FFFFFFFF) begin
            n_fail++;
            $display("FAIL div_by_zero: hi=%h lo=%h, want FFFFFFF0 FFFFFFFF", hi, lo);
        end
        run_op(DIV, 32'h80000000, 32'hFFFFFFFF, cyc);
        @(negedge clk);
        n_checks++;
        if ({hi, lo} !== 64'h00000000_80000000) begin
            n_fail++;
            $display("FAIL div_overflow: hi=%h lo=%h, want 00000000 80000000", hi, lo);
        end
    endtask

    task automatic test_flush;
        int cyc;
        int seen_done;
        @(negedge clk);
        hi_we = 1'b1; lo_we = 1'b1; hi_data = 32'hAAAA0000; lo_data = 32'h00005555;
        @(posedge clk);
        #1 hi_we = 1'b0; lo_we = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({hi, lo} !== 64'hAAAA0000_00005555) begin
            n_fail++;
            $display("FAIL direct_write: hi=%h lo=%h, want AAAA0000 00005555", hi, lo);
        end
        start = 1'b1; op = DIVU; a = 32'd1000; b = 32'd3;
        @(posedge clk);
        #1 start = 1'b0;
        seen_done = 0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (done) seen_done++;
        end
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) seen_done++;
            if (i == 0) begin
                n_checks++;
                if (busy !== 1'b0) begin
                    n_fail++;
                    $display("FAIL flush_busy: busy=%b, want 0", busy);
                end
            end
        end
        n_checks++;
        if (seen_done !== 0 || {hi, lo} !== 64'hAAAA0000_00005555) begin
            n_fail++;
            $display("FAIL flush_result: done_count=%0d hi=%h lo=%h, want 0 AAAA0000 00005555",
                     seen_done, hi, lo);
        end
        run_op(MULTU, 32'd2, 32'd3, cyc);
        @(negedge clk);
        n_checks++;
        if (cyc !== 33 || {hi, lo} !== 64'h00000000_00000006) begin
            n_fail++;
            $display("FAIL after_flush: cycles=%0d hi=%h lo=%h, want 33 00000000 00000006", cyc, hi, lo);
        end
        // flush in IDLE blocks start but a same-cycle direct write still lands
        start = 1'b1; flush = 1'b1; op = MULTU; a = 32'd9; b = 32'd9;
        lo_we = 1'b1; lo_data = 32'h00000077;
        @(posedge clk);
        #1 start = 1'b0; flush = 1'b0; lo_we = 1'b0;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || lo !== 32'h00000077) begin
            n_fail++;
            $display("FAIL idle_flush: busy=%b lo=%h, want 0 00000077", busy, lo);
        end
    endtask

    task automatic test_busy_write;
        int cyc;
        @(negedge clk);
        start = 1'b1; op = MULTU; a = 32'd7; b = 32'd6;
        @(posedge clk);
        #1 start = 1'b0;
        cyc = 0;
        while (cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (done) break;
            if (cyc == 5) begin
                hi_we = 1'b1; hi_data = 32'hDEADBEEF;
                start = 1'b1; op = DIV; a = 32'd100; b = 32'd10;
            end else begin
                hi_we = 1'b0; start = 1'b0;
            end
        end
        hi_we = 1'b0; start = 1'b0;
        n_checks++;
        if (cyc !== 33) begin
            n_fail++;
            $display("FAIL busy_latency: done after %0d cycles, want 33", cyc);
        end
        @(negedge clk);
        n_checks++;
        if ({hi, lo} !== 64'h00000000_0000002A) begin
            n_fail++;
            $display("FAIL busy_write: hi=%h lo=%h, want 00000000 0000002A", hi, lo);
        end
        start = 1'b1; op = MULTU; a = 32'd3; b = 32'd5;
        hi_we = 1'b1; hi_data = 32'hDEADBEEF;
        @(posedge clk);
        #1 start = 1'b0; hi_we = 1'b0;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b1 || hi !== 32'h00000000) begin
            n_fail++;
            $display("FAIL start_with_write: busy=%b hi=%h, want 1 00000000", busy, hi);
        end
        cyc = 0;
        while (cyc < 100 && !done) begin
            @(negedge clk);
            cyc++;
        end
        @(negedge clk);
        n_checks++;
        if ({hi, lo} !== 64'h00000000_0000000F) begin
            n_fail++;
            $display("FAIL start_with_write_result: hi=%h lo=%h, want 00000000 0000000F", hi, lo);
        end
    endtask

    task automatic test_async_reset;
        int cyc;
        run_op(MULTU, 32'h00010000, 32'h00030000, cyc);
        @(negedge clk);
        @(negedge clk);
        start = 1'b1; op = MULTU; a = 32'd5; b = 32'd5;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (5) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        n_checks++;
        if ({busy, done, hi, lo} !== 66'd0) begin
            n_fail++;
            $display("FAIL async_reset: busy=%b done=%b hi=%h lo=%h, want all 0", busy, done, hi, lo);
        end
        @(negedge clk);
        reset = 1'b0;
        run_op(MULTU, 32'd2, 32'd3, cyc);
        @(negedge clk);
        n_checks++;
        if (cyc !== 33 || {hi, lo} !== 64'h00000000_00000006) begin
            n_fail++;
            $display("FAIL after_reset: cycles=%0d hi=%h lo=%h, want 33 00000000 00000006", cyc, hi, lo);
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; op = MULTU; a = '0; b = '0; flush = 1'b0;
        hi_we = 1'b0; lo_we = 1'b0; hi_data = '0; lo_data = '0;
        #1;
        test_reset;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        test_multu_max;
        test_signed;
        test_div_special;
        test_flush;
        test_busy_write;
        test_async_reset;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
